// File: rtl/spart_pkg.sv
// -----------------------------------------------------------------------------
// spart_pkg: definitions shared by the SPART blocks.
//   tx_state_t   : transmitter FSM states
//   START_BIT    : line level of the start bit
//   STOP_BIT     : line level of the stop bit and of the idle line
//   ADDR_*       : ioaddr decode values used by the SPART top
//   DIV_*        : divisor values for a 50 MHz clock (bit period minus one)
//   baud_divisor : maps a baud selection onto its 50 MHz divisor
// -----------------------------------------------------------------------------
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DB_LO  = 2'b10;
  localparam logic [1:0] ADDR_DB_HI  = 2'b11;

  localparam logic [15:0] DIV_4800  = 16'd10415;
  localparam logic [15:0] DIV_9600  = 16'd5207;
  localparam logic [15:0] DIV_19200 = 16'd2603;
  localparam logic [15:0] DIV_38400 = 16'd1301;

  typedef enum logic [1:0] {
    BAUD_4800  = 2'b00,
    BAUD_9600  = 2'b01,
    BAUD_19200 = 2'b10,
    BAUD_38400 = 2'b11
  } baud_sel_t;

  function automatic logic [15:0] baud_divisor(input baud_sel_t sel);
    case (sel)
      BAUD_4800:  return DIV_4800;
      BAUD_9600:  return DIV_9600;
      BAUD_19200: return DIV_19200;
      BAUD_38400: return DIV_38400;
      default:    return DIV_9600;
    endcase
  endfunction

endpackage

// File: rtl/spart_baud_cnt.sv
// -----------------------------------------------------------------------------
// spart_baud_cnt: loadable bit-period down-counter.
//   clk     : system clock
//   rst     : asynchronous active-high reset (counter cleared)
//   reload  : load the counter with divisor at this edge
//   divisor : bit period minus one, in clk cycles
//   bit_end : high during the last cycle of the current bit period
// The counter stops at zero, so when it is not reloaded it parks there.
// -----------------------------------------------------------------------------
module spart_baud_cnt
  import spart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reload,
  input  logic [DIV_W-1:0] divisor,
  output logic             bit_end
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Next count: reload, else decrement down to zero and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = divisor;
    end else if (cnt_q != {DIV_W{1'b0}}) begin
      cnt_d = cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {DIV_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = (cnt_q == {DIV_W{1'b0}});

endmodule

// File: rtl/spart_tx.sv
// -----------------------------------------------------------------------------
// spart_tx: SPART transmitter with one holding byte and one shift register.
//   clk     : system clock
//   rst     : asynchronous active-high reset; aborts any frame
//   load    : write strobe for the data register
//   tx_data : byte to transmit, sampled when load=1
//   divisor : bit period minus one; sampled once per frame at frame start
//   txd     : serial line, idle high, driven from a flop
//   tbr     : transmit buffer ready (holding buffer empty), registered
// Frame = start bit, DATA_W data bits LSB first, stop bit.
// -----------------------------------------------------------------------------
module spart_tx
  import spart_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [DIV_W-1:0]  divisor,
  output logic              txd,
  output logic              tbr
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              txd_q, txd_d;
  logic              tbr_q, tbr_d;

  logic              take_s;
  logic              reload_s;
  logic [DIV_W-1:0]  reload_div_s;
  logic              bit_end_s;

  spart_baud_cnt #(.DIV_W(DIV_W)) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .reload  (reload_s),
    .divisor (reload_div_s),
    .bit_end (bit_end_s)
  );

  // Next-state, line level and buffer logic.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    bit_cnt_d    = bit_cnt_q;
    div_d        = div_q;
    txd_d        = txd_q;
    take_s       = 1'b0;
    reload_s     = 1'b0;
    reload_div_s = div_q;

    case (state_q)
      IDLE: begin
        txd_d = STOP_BIT;
        if (hold_full_q) begin
          take_s = 1'b1;
        end else begin
          take_s = 1'b0;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d  = DATA;
          reload_s = 1'b1;
          txd_d    = shift_q[0];
        end else begin
          txd_d = START_BIT;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_d  = shift_q >> 1;
          reload_s = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
            txd_d   = STOP_BIT;
          end else begin
            bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            txd_d     = shift_d[0];
          end
        end else begin
          txd_d = shift_q[0];
        end
      end
      STOP: begin
        if (bit_end_s) begin
          if (hold_full_q) begin
            // Back-to-back: the next start bit follows the stop bit directly.
            take_s = 1'b1;
          end else begin
            state_d = IDLE;
            txd_d   = STOP_BIT;
          end
        end else begin
          txd_d = STOP_BIT;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = STOP_BIT;
      end
    endcase

    // Frame launch: move the held byte into the shifter and latch this
    // frame's divisor, which then governs every bit of the frame.
    if (take_s) begin
      state_d      = START;
      shift_d      = hold_q;
      hold_full_d  = 1'b0;
      bit_cnt_d    = {CNT_W{1'b0}};
      div_d        = divisor;
      reload_s     = 1'b1;
      reload_div_s = divisor;
      txd_d        = START_BIT;
    end else begin
      reload_div_s = div_q;
    end

    // A write is accepted whenever the buffer is, or is just becoming, empty.
    if (load && !hold_full_d) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end

    tbr_d = ~hold_full_d;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= {DATA_W{1'b0}};
      hold_q      <= {DATA_W{1'b0}};
      hold_full_q <= 1'b0;
      bit_cnt_q   <= {CNT_W{1'b0}};
      div_q       <= {DIV_W{1'b0}};
      txd_q       <= STOP_BIT;
      tbr_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      div_q       <= div_d;
      txd_q       <= txd_d;
      tbr_q       <= tbr_d;
    end
  end

  assign txd = txd_q;
  assign tbr = tbr_q;

endmodule

// File: tb/tb_spart_tx.sv
// -----------------------------------------------------------------------------
// tb_spart_tx: scoreboard bench for spart_tx.
// A reference process decides, edge by edge, which writes are accepted and
// when each accepted byte begins on the line, and queues the expected frame.
// A monitor pops a frame when the line drops and checks every line cycle.
// -----------------------------------------------------------------------------
module tb_spart_tx;
  localparam int DIV_W  = 16;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              load;
  logic [DATA_W-1:0] tx_data;
  logic [DIV_W-1:0]  divisor;
  logic              txd;
  logic              tbr;

  always #5 clk = ~clk;

  spart_tx #(.DIV_W(DIV_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .tx_data (tx_data),
    .divisor (divisor),
    .txd     (txd),
    .tbr     (tbr)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    int                div;
    int                start_edge;
  } frame_t;

  frame_t sb_q[$];
  int     n_compared   = 0;
  int     n_mismatched = 0;

  // reference model state
  int                edge_n    = 0;
  bit                buf_valid = 1'b0;
  logic [DATA_W-1:0] buf_data  = '0;
  int                buf_edge  = 0;
  int                line_end  = 0;

  // monitor state
  bit     in_frame = 1'b0;
  frame_t cur;
  int     cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic exp_bit(input frame_t f, input int c);
    int idx;
    idx = c / (f.div + 1);
    if (idx == 0) return 1'b0;
    else if (idx <= DATA_W) return f.data[idx-1];
    else return 1'b1;
  endfunction

  // Reference model: a byte sits in the buffer until the line is free
  // (the previous frame's last edge) and at least one edge after its write.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        buf_valid = 1'b0;
        line_end  = 0;
        sb_q.delete();
      end else begin
        if (buf_valid && buf_edge < edge_n && edge_n >= line_end) begin
          sb_q.push_back('{data: buf_data, div: int'(divisor), start_edge: edge_n});
          line_end  = edge_n + (DATA_W + 2) * (int'(divisor) + 1);
          buf_valid = 1'b0;
        end
        if (load && !buf_valid) begin
          buf_valid = 1'b1;
          buf_data  = tx_data;
          buf_edge  = edge_n;
        end
      end
    end
  end

  // Monitor: checks tbr every cycle and every line cycle of every frame.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
      end else begin
        check("tbr", tbr, !buf_valid);
        if (in_frame) begin
          check("txd_bit", txd, exp_bit(cur, cyc));
          cyc++;
          if (cyc == (DATA_W + 2) * (cur.div + 1)) in_frame = 1'b0;
        end else if (txd === 1'b0) begin
          check("start_expected", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            check("start_edge", edge_n, cur.start_edge);
            in_frame = 1'b1;
            cyc      = 0;
            check("txd_bit", txd, exp_bit(cur, cyc));
            cyc      = 1;
          end
        end
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] b);
    @(posedge clk); #2;
    load = 1'b1; tx_data = b;
    @(posedge clk); #2;
    load = 1'b0;
  endtask

  task automatic send3(input logic [DATA_W-1:0] b0, input logic [DATA_W-1:0] b1,
                       input logic [DATA_W-1:0] b2);
    @(posedge clk); #2; load = 1'b1; tx_data = b0;
    @(posedge clk); #2; tx_data = b1;
    @(posedge clk); #2; tx_data = b2;
    @(posedge clk); #2; load = 1'b0;
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(posedge clk);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (!(sb_q.size() == 0 && !in_frame && !buf_valid && edge_n >= line_end) && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("drain_in_budget", k < budget, 1);
    wait_cycles(3);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst_txd", txd, 1);
    check("rst_tbr", tbr, 1);
    @(posedge clk); #3;
    rst = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load = 1'b0; tx_data = '0; divisor = 16'd3;
    #1;
    check("reset_txd", txd, 1);
    check("reset_tbr", tbr, 1);
    wait_cycles(3); #3;
    rst = 1'b0;
    wait_cycles(5);

    // single frame, divisor 3
    send(8'hA6);
    drain(200);

    // second byte written during the first frame: back-to-back frames
    send(8'h59);
    wait_cycles(10);
    send(8'h3C);
    drain(300);

    // three consecutive writes: the third is dropped
    send3(8'h11, 8'h22, 8'h33);
    drain(300);

    // divisor 0, then divisor changed mid-frame
    divisor = 16'd0;
    send(8'hFF);
    wait_cycles(2); #2;
    divisor = 16'd7;
    drain(100);
    send(8'h81);
    drain(300);

    // reset mid-frame with the buffer full, then stay idle
    divisor = 16'd3;
    send(8'hA6);
    send(8'h77);
    wait_cycles(14);
    pulse_reset();
    wait_cycles(120);
    check("idle_after_reset", txd, 1);
    check("tbr_after_reset", tbr, 1);

    // randomized writes, gaps and divisors
    for (int i = 0; i < 60; i++) begin
      wait_cycles($urandom_range(0, 25)); #2;
      divisor = 16'($urandom_range(0, 4));
      load    = 1'b1;
      tx_data = 8'($urandom_range(0, 255));
      @(posedge clk); #2;
      load = 1'b0;
    end
    drain(5000);

    // 9600 baud at 50 MHz
    divisor = 16'd5207;
    send(8'h55);
    drain(60000);

    check("final_queue_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
